// File: rtl/ct_idu_id_split_fence_seq.sv
`default_nettype none
// ============================================================================
// Module   : ct_idu_id_split_fence_seq
// Brief    : Captures one ID-stage instruction, drains the backend around
//            fences, then issues 1 or 2 micro-ops to IR under valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module ct_idu_id_split_fence_seq #(
   parameter int CNT_W      = 8,
   parameter int FENCE_POST = 1
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             rtu_idu_flush,
   input  logic             rtu_idu_empty,
   input  logic             id_inst_vld,
   input  logic [31:0]      id_inst,
   input  logic [3:0]       id_split_short,
   input  logic [2:0]       id_fence,
   output logic             id_inst_ready,
   output logic             uop_vld,
   input  logic             uop_ready,
   output logic [31:0]      uop_inst,
   output logic             uop_idx,
   output logic             uop_last,
   output logic [3:0]       uop_split_type,
   output logic             uop_fence,
   output logic [CNT_W-1:0] fence_wait_cnt
);

   localparam logic             c_post    = (FENCE_POST != 0);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FWAIT = 2'd1,
      S_EMIT  = 2'd2,
      S_FPOST = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_inst;
   logic [3:0]       r_split;
   logic             r_fence;
   logic             r_nuop2;
   logic             r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             w_emit;
   logic             w_cap;
   logic             w_uop_hs;

   always_comb begin
      w_emit         = (r_state == S_EMIT);
      uop_vld        = w_emit;
      uop_last       = w_emit && (!r_nuop2 || r_idx);
      w_uop_hs       = uop_vld && uop_ready;
      // A non-fence last uop leaving this cycle frees the slot for a new capture.
      id_inst_ready  = !rtu_idu_flush &&
                       ((r_state == S_IDLE) ||
                        (uop_last && uop_ready && !(r_fence && c_post)));
      w_cap          = id_inst_vld && id_inst_ready;
      uop_inst       = r_inst;
      uop_idx        = r_idx;
      uop_split_type = r_split;
      uop_fence      = r_fence;
      fence_wait_cnt = r_cnt;

      w_next = r_state;
      if (rtu_idu_flush) begin
         w_next = S_IDLE;
      end else if (w_cap) begin
         w_next = (|id_fence) ? S_FWAIT : S_EMIT;
      end else begin
         case (r_state)
            S_FWAIT: if (rtu_idu_empty) w_next = S_EMIT;
            S_EMIT:  if (w_uop_hs && uop_last) w_next = (r_fence && c_post) ? S_FPOST : S_IDLE;
            S_FPOST: if (rtu_idu_empty) w_next = S_IDLE;
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_inst  <= 32'd0;
         r_split <= 4'd0;
         r_fence <= 1'b0;
         r_nuop2 <= 1'b0;
         r_idx   <= 1'b0;
      end else if (w_cap) begin
         r_inst  <= id_inst;
         r_split <= id_split_short;
         r_fence <= |id_fence;
         r_nuop2 <= |id_split_short;
         r_idx   <= 1'b0;
      end else if (!rtu_idu_flush && w_uop_hs && !uop_last) begin
         r_idx   <= 1'b1;
      end
   end

   // Counter survives flush so the last fence's drain time stays observable.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_cnt <= '0;
      end else if (rtu_idu_flush) begin
         r_cnt <= r_cnt;
      end else if (w_cap) begin
         r_cnt <= '0;
      end else if ((r_state == S_FWAIT) && (r_cnt != c_cnt_max)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ct_idu_id_split_fence_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_idu_id_split_fence_seq
// Brief    : Randomized bench for the split/fence sequencer against a
//            queue-based transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ct_idu_id_split_fence_seq;

   localparam int CNT_W      = 4;
   localparam int FENCE_POST = 1;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             rtu_idu_flush, rtu_idu_empty, id_inst_vld, uop_ready;
   logic [31:0]      id_inst;
   logic [3:0]       id_split_short;
   logic [2:0]       id_fence;
   logic             id_inst_ready, uop_vld, uop_idx, uop_last, uop_fence;
   logic [31:0]      uop_inst;
   logic [3:0]       uop_split_type;
   logic [CNT_W-1:0] fence_wait_cnt;

   ct_idu_id_split_fence_seq #(.CNT_W(CNT_W), .FENCE_POST(FENCE_POST)) u_dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .rtu_idu_flush  (rtu_idu_flush),
      .rtu_idu_empty  (rtu_idu_empty),
      .id_inst_vld    (id_inst_vld),
      .id_inst        (id_inst),
      .id_split_short (id_split_short),
      .id_fence       (id_fence),
      .id_inst_ready  (id_inst_ready),
      .uop_vld        (uop_vld),
      .uop_ready      (uop_ready),
      .uop_inst       (uop_inst),
      .uop_idx        (uop_idx),
      .uop_last       (uop_last),
      .uop_split_type (uop_split_type),
      .uop_fence      (uop_fence),
      .fence_wait_cnt (fence_wait_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        idx;
      logic        last;
      logic [3:0]  split;
      logic        fence;
   } uop_t;

   // Model: pending uops of the held instruction plus drain obligations.
   uop_t q[$];
   bit   need_pre, need_post;
   int   cnt;
   int   n_cmp = 0;
   int   n_err = 0;
   int   p_vld, p_split, p_fence, p_rdy, p_empty, p_flush;
   bit   fixed_split;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   task automatic model_clear();
      q.delete();
      need_pre  = 0;
      need_post = 0;
      cnt       = 0;
   endtask

   task automatic drive_random();
      id_inst_vld   = pct(p_vld);
      id_inst       = $urandom;
      if (fixed_split)         id_split_short = 4'b0001;
      else if (pct(p_split))   id_split_short = pct(70) ? (4'b0001 << $urandom_range(3)) : 4'($urandom_range(15));
      else                     id_split_short = 4'd0;
      id_fence      = pct(p_fence) ? 3'($urandom_range(7, 1)) : 3'd0;
      uop_ready     = pct(p_rdy);
      rtu_idu_empty = pct(p_empty);
      rtu_idu_flush = pct(p_flush);
   endtask

   // Compare this cycle's outputs, then advance the model across the next edge.
   task automatic step();
      bit   exp_vld, exp_rdy, hs_id, hs_uop;
      uop_t u;
      #1;
      exp_vld = (q.size() != 0) && !need_pre;
      exp_rdy = !rtu_idu_flush &&
                (((q.size() == 0) && !need_post) ||
                 ((q.size() == 1) && exp_vld && uop_ready && !(q[0].fence && FENCE_POST != 0)));
      chk("uop_vld", 32'(uop_vld), 32'(exp_vld));
      chk("id_inst_ready", 32'(id_inst_ready), 32'(exp_rdy));
      chk("fence_wait_cnt", 32'(fence_wait_cnt), 32'(cnt));
      if (exp_vld) begin
         chk("uop_inst", uop_inst, q[0].inst);
         chk("uop_idx", 32'(uop_idx), 32'(q[0].idx));
         chk("uop_last", 32'(uop_last), 32'(q[0].last));
         chk("uop_split_type", 32'(uop_split_type), 32'(q[0].split));
         chk("uop_fence", 32'(uop_fence), 32'(q[0].fence));
      end
      hs_id  = id_inst_vld && exp_rdy;
      hs_uop = exp_vld && uop_ready;
      @(posedge clk);
      if (rtu_idu_flush) begin
         q.delete();
         need_pre  = 0;
         need_post = 0;
      end else begin
         if (need_post && rtu_idu_empty) need_post = 0;
         if (need_pre) begin
            if (cnt < CNT_MAX) cnt++;
            if (rtu_idu_empty) need_pre = 0;
         end
         if (hs_uop) begin
            u = q.pop_front();
            if (u.last && u.fence && FENCE_POST != 0) need_post = 1;
         end
         if (hs_id) begin
            int n;
            n   = (id_split_short != 0) ? 2 : 1;
            cnt = 0;
            for (int i = 0; i < n; i++) begin
               u.inst  = id_inst;
               u.idx   = 1'(i);
               u.last  = (i == n - 1);
               u.split = id_split_short;
               u.fence = (id_fence != 0);
               q.push_back(u);
            end
            need_pre = (id_fence != 0);
         end
      end
      #1;
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         drive_random();
         step();
      end
   endtask

   task automatic knobs(input int v, input int s, input int f, input int r, input int e, input int fl);
      p_vld = v; p_split = s; p_fence = f; p_rdy = r; p_empty = e; p_flush = fl;
   endtask

   task automatic check_reset_values();
      chk("rst uop_vld", 32'(uop_vld), 32'd0);
      chk("rst uop_idx", 32'(uop_idx), 32'd0);
      chk("rst uop_last", 32'(uop_last), 32'd0);
      chk("rst uop_fence", 32'(uop_fence), 32'd0);
      chk("rst uop_split_type", 32'(uop_split_type), 32'd0);
      chk("rst uop_inst", uop_inst, 32'd0);
      chk("rst fence_wait_cnt", 32'(fence_wait_cnt), 32'd0);
      chk("rst id_inst_ready", 32'(id_inst_ready), 32'd1);
   endtask

   initial begin
      fixed_split = 0;
      knobs(0, 0, 0, 0, 0, 0);
      drive_random();
      rst = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Plain single-uop instructions, IR always ready, backend empty.
      knobs(100, 0, 0, 100, 100, 0);
      run(20);
      // Split instructions with IR stalls.
      knobs(60, 100, 0, 40, 100, 0);
      run(60);
      // Fences with a slow-draining backend.
      knobs(50, 30, 100, 70, 20, 0);
      run(80);
      // Backend never empties long enough: counter must saturate.
      knobs(100, 0, 100, 100, 0, 0);
      run(30);
      knobs(0, 0, 0, 100, 100, 0);
      run(10);
      // Back-to-back two-uop instructions with no bubbles.
      fixed_split = 1;
      knobs(100, 100, 0, 100, 100, 0);
      run(30);
      fixed_split = 0;
      // Mixed traffic with flushes.
      knobs(60, 40, 25, 70, 40, 8);
      run(400);

      // Asynchronous reset in the middle of traffic.
      knobs(80, 50, 50, 50, 30, 0);
      run(7);
      drive_random();
      rst = 1'b1;
      #1;
      rtu_idu_flush = 1'b0;
      #1;
      check_reset_values();
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      knobs(60, 40, 25, 70, 40, 4);
      run(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
